// File: rtl/rotary_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared definitions for the quadrature rotary encoder decoder.
//   - Gray-code phase constants ({A,B})
//   - step classification enum and FSM state enum
//   - accumulator width / detent length and derived signed limits
//   - helper functions: clockwise successor of a phase, step classifier
// -----------------------------------------------------------------------------
package rotary_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_CW   = 2'b01,
        STEP_CCW  = 2'b10,
        STEP_ERR  = 2'b11
    } step_t;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam int ACC_W        = 4;
    localparam int DETENT_STEPS = 4;

    localparam logic signed [ACC_W-1:0] ACC_ZERO = ACC_W'(0);
    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    // Partial turns saturate one short of a full detent.
    localparam logic signed [ACC_W-1:0] ACC_SAT_P  = ACC_W'(DETENT_STEPS - 1);
    localparam logic signed [ACC_W-1:0] ACC_SAT_N  = ACC_W'(-(DETENT_STEPS - 1));
    localparam logic signed [ACC_W-1:0] ACC_FULL_P = ACC_W'(DETENT_STEPS);
    localparam logic signed [ACC_W-1:0] ACC_FULL_N = ACC_W'(-DETENT_STEPS);

    // Next phase in the clockwise sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    // Classify a move from prev to cur; a two-bit change is illegal.
    function automatic step_t classify(input logic [1:0] prev, input logic [1:0] cur);
        step_t st;
        if (cur == prev) begin
            st = STEP_NONE;
        end else if (cur == cw_next(prev)) begin
            st = STEP_CW;
        end else if (prev == cw_next(cur)) begin
            st = STEP_CCW;
        end else begin
            st = STEP_ERR;
        end
        return st;
    endfunction

endpackage

// File: rtl/rotary_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
// One encoder channel: SYNC_STAGES-flop synchronizer followed by a debounce
// filter. The filtered bit toggles only after the synchronized bit has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// Build option: ROTARY_DEBOUNCE_EN -- when undefined the filter is removed
// and filt follows sync directly (DEBOUNCE_CYCLES is then ignored).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   raw   : raw pin, asynchronous to clk
//   load  : force filt to the current synchronized value, clear counter
//   sync  : synchronized pin value
//   filt  : debounced pin value
// -----------------------------------------------------------------------------
module rotary_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic load,
    output logic sync,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Synchronizer chain: raw enters at bit 0, sync is taken from the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_r[SYNC_STAGES-1];

`ifdef ROTARY_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Counter value at which the next disagreeing cycle completes the window.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             filt_r;
    logic             filt_s;

    // Filter next-state: clear on agreement, toggle after a full stable window.
    always_comb begin
        cnt_s  = cnt_r;
        filt_s = filt_r;
        if (load) begin
            filt_s = sync;
            cnt_s  = {CNT_W{1'b0}};
        end else if (sync == filt_r) begin
            cnt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            filt_s = ~filt_r;
            cnt_s  = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_r + CNT_W'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            filt_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            filt_r <= filt_s;
        end
    end

    assign filt = filt_r;
`else
    // Without the filter the load request has nothing to act on.
    logic unused_load;
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign unused_load = load;
    assign filt        = sync;
`endif

endmodule

// File: rtl/rotary_decoder.sv
// -----------------------------------------------------------------------------
// rotary_decoder
// Quadrature rotary encoder front end: synchronizes and debounces ROT_A/ROT_B,
// tracks the Gray-code phase and emits one rotary_event pulse per complete
// detent with a registered direction flag.
// Build option: ROTARY_DEBOUNCE_EN (see rotary_debounce).
// Ports:
//   CLK          : clock, rising edge
//   RST_N        : asynchronous active-low reset
//   ROT_A, ROT_B : raw encoder channels, asynchronous to CLK
//   rotary_event : one-cycle pulse per completed detent
//   rotary_right : direction of the last detent (1 = clockwise), held
//   rotary_err   : one-cycle pulse on an illegal two-bit phase jump
// -----------------------------------------------------------------------------
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ROT_A,
    input  logic ROT_B,
    output logic rotary_event,
    output logic rotary_right,
    output logic rotary_err
);

    // INIT stays until the synchronizers hold post-reset samples of the pins,
    // so the phase loaded into the filters matches the encoder's real position.
    localparam int               INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    logic sync_a_s, sync_b_s, filt_a_s, filt_b_s;
    logic load_s;

    rotary_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk  (CLK),
        .rst_n(RST_N),
        .raw  (ROT_A),
        .load (load_s),
        .sync (sync_a_s),
        .filt (filt_a_s)
    );

    rotary_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk  (CLK),
        .rst_n(RST_N),
        .raw  (ROT_B),
        .load (load_s),
        .sync (sync_b_s),
        .filt (filt_b_s)
    );

    state_t                   state_r, state_s;
    logic [INIT_W-1:0]        init_cnt_r, init_cnt_s;
    logic [1:0]               prev_r, prev_s;
    logic signed [ACC_W-1:0]  acc_r, acc_s;
    logic signed [ACC_W-1:0]  acc_step_s;
    logic                     event_r, event_s;
    logic                     right_r, right_s;
    logic                     err_r, err_s;

    logic [1:0] phase_s;
    logic [1:0] sync_phase_s;
    step_t      step_s;

    assign phase_s      = {filt_a_s, filt_b_s};
    assign sync_phase_s = {sync_a_s, sync_b_s};
    assign step_s       = classify(prev_r, phase_s);

    // FSM next-state, step accumulation and output decode.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        prev_s     = prev_r;
        acc_s      = acc_r;
        acc_step_s = acc_r;
        event_s    = 1'b0;
        right_s    = right_r;
        err_s      = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            ST_INIT: begin
                load_s = 1'b1;
                prev_s = sync_phase_s;
                acc_s  = ACC_ZERO;
                if (init_cnt_r == INIT_LAST) begin
                    state_s    = ST_TRACK;
                    init_cnt_s = {INIT_W{1'b0}};
                end else begin
                    init_cnt_s = init_cnt_r + INIT_W'(1);
                end
            end
            ST_TRACK: begin
                prev_s = phase_s;
                case (step_s)
                    STEP_CW:  acc_step_s = acc_r + ACC_ONE;
                    STEP_CCW: acc_step_s = acc_r - ACC_ONE;
                    STEP_ERR: begin
                        err_s = 1'b1;
                        acc_s = ACC_ZERO;
                    end
                    default:  acc_step_s = acc_r;
                endcase
                if ((step_s == STEP_CW) || (step_s == STEP_CCW)) begin
                    if (phase_s == PH_00) begin
                        // Landing on the detent rest phase always restarts the count.
                        acc_s = ACC_ZERO;
                        if (acc_step_s == ACC_FULL_P) begin
                            event_s = 1'b1;
                            right_s = 1'b1;
                        end else if (acc_step_s == ACC_FULL_N) begin
                            event_s = 1'b1;
                            right_s = 1'b0;
                        end else begin
                            event_s = 1'b0;
                        end
                    end else if (acc_step_s > ACC_SAT_P) begin
                        acc_s = ACC_SAT_P;
                    end else if (acc_step_s < ACC_SAT_N) begin
                        acc_s = ACC_SAT_N;
                    end else begin
                        acc_s = acc_step_s;
                    end
                end else begin
                    event_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {INIT_W{1'b0}};
            prev_r     <= PH_00;
            acc_r      <= ACC_ZERO;
            event_r    <= 1'b0;
            right_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            prev_r     <= prev_s;
            acc_r      <= acc_s;
            event_r    <= event_s;
            right_r    <= right_s;
            err_r      <= err_s;
        end
    end

    assign rotary_event = event_r;
    assign rotary_right = right_r;
    assign rotary_err   = err_r;

endmodule

// File: tb/tb_rotary_decoder.sv
// -----------------------------------------------------------------------------
// tb_rotary_decoder
// Scoreboard bench: each stimulus phase that should produce an output pushes
// the expected pulse (cycle, kind, direction) onto a queue; a monitor on the
// falling edge pops and compares every pulse the decoder produces.
// -----------------------------------------------------------------------------
module tb_rotary_decoder;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef ROTARY_DEBOUNCE_EN
    localparam int LAT  = SYNC + DEB + 1;
`else
    localparam int LAT  = SYNC + 1;
`endif
    localparam int HOLD = 10;

    localparam logic [1:0] K_NONE = 2'b00;
    localparam logic [1:0] K_EV   = 2'b10;
    localparam logic [1:0] K_ERR  = 2'b01;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic ROT_A = 1'b0;
    logic ROT_B = 1'b0;
    logic rotary_event, rotary_right, rotary_err;

    rotary_decoder #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ROT_A       (ROT_A),
        .ROT_B       (ROT_B),
        .rotary_event(rotary_event),
        .rotary_right(rotary_right),
        .rotary_err  (rotary_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
        logic       right;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (rotary_event || rotary_err) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", 32'({rotary_event, rotary_err}), 32'(K_NONE));
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                check_eq("pulse_kind", 32'({rotary_event, rotary_err}), 32'(mon_e.kind));
                if (mon_e.kind == K_EV) begin
                    check_eq("pulse_dir", 32'(rotary_right), 32'(mon_e.right));
                end
            end
        end
    end

    // Drive phase {A,B} just after a rising edge and hold it; record expectation.
    task automatic apply(input logic [1:0] ph, input int hold, input logic [1:0] kind,
                         input logic right);
        exp_t e;
        @(posedge CLK);
        #1;
        {ROT_A, ROT_B} = ph;
        if (kind != K_NONE) begin
            e.cyc   = cyc + LAT;
            e.kind  = kind;
            e.right = right;
            exp_q.push_back(e);
        end
        repeat (hold - 1) @(posedge CLK);
    endtask

    // Let outstanding pulses drain, then require none still pending.
    task automatic settle(input string tag);
        repeat (LAT + 6) @(posedge CLK);
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic detent_cw();
        apply(2'b01, HOLD, K_NONE, 1'b0);
        apply(2'b11, HOLD, K_NONE, 1'b0);
        apply(2'b10, HOLD, K_NONE, 1'b0);
        apply(2'b00, HOLD, K_EV,   1'b1);
    endtask

    task automatic check_outputs_low(input string tag);
        check_eq({tag, "_event"}, 32'(rotary_event), 32'd0);
        check_eq({tag, "_right"}, 32'(rotary_right), 32'd0);
        check_eq({tag, "_err"},   32'(rotary_err),   32'd0);
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(negedge CLK);
        check_outputs_low("por");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (8) @(posedge CLK);

        // Clean clockwise detent.
        detent_cw();
        settle("cw");
        check_eq("cw_right_held", 32'(rotary_right), 32'd1);

        // Counter-clockwise detent.
        apply(2'b10, HOLD, K_NONE, 1'b0);
        apply(2'b11, HOLD, K_NONE, 1'b0);
        apply(2'b01, HOLD, K_NONE, 1'b0);
        apply(2'b00, HOLD, K_EV,   1'b0);
        settle("ccw");
        check_eq("ccw_right_held", 32'(rotary_right), 32'd0);

        // Bounce on A: short pulses, no output expected.
        for (int i = 0; i < 5; i++) begin
            apply(2'b10, 3, K_NONE, 1'b0);
            apply(2'b00, 6, K_NONE, 1'b0);
        end
        settle("bounce");
        check_eq("bounce_acc", 32'(dut.acc_r), 32'd0);

        // Half turn and back, then a full clockwise detent.
        apply(2'b01, HOLD, K_NONE, 1'b0);
        apply(2'b11, HOLD, K_NONE, 1'b0);
        apply(2'b01, HOLD, K_NONE, 1'b0);
        apply(2'b00, HOLD, K_NONE, 1'b0);
        settle("half");
        detent_cw();
        settle("half_cw");
        check_eq("half_cw_right", 32'(rotary_right), 32'd1);

        // Illegal jump 00 -> 11, walk back to 00, then a clean detent.
        apply(2'b11, HOLD, K_ERR,  1'b0);
        apply(2'b10, HOLD, K_NONE, 1'b0);
        apply(2'b00, HOLD, K_NONE, 1'b0);
        settle("jump");
        detent_cw();
        settle("jump_cw");

        // Reset in the middle of a detent.
        apply(2'b01, HOLD, K_NONE, 1'b0);
        apply(2'b11, HOLD, K_NONE, 1'b0);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_outputs_low("mid_rst");
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (20) @(posedge CLK);
        settle("post_rst");
        apply(2'b10, HOLD, K_NONE, 1'b0);
        apply(2'b00, HOLD, K_NONE, 1'b0);
        settle("post_rst_turn");
        check_outputs_low("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
